// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
//   Multi-chain scan register with a command-driven capture/shift/update
//   sequencer. Each chain is a WIDTH-bit shift register plus a WIDTH-bit
//   shadow register. All chains shift in lockstep. A single accepted command
//   can capture parallel D, shift LEN bits, and/or update the shadow Q.
//
// Ports
//   CLK        rising-edge clock
//   RST        synchronous reset, active-high
//   CMD_VALID  command request
//   CMD_READY  controller idle; a command is accepted on VALID & READY
//   CMD_CAP    capture D into the shift registers before shifting
//   CMD_UPD    copy the shift registers into Q after shifting
//   CMD_LEN    number of shift cycles (values above WIDTH clamp to WIDTH)
//   SI         serial input, bit c feeds chain c
//   SO         serial output, bit 0 of each chain's shift register
//   D          capture data, chain c at [c*WIDTH +: WIDTH]
//   Q          shadow outputs, same packing as D
//   BUSY       high whenever the sequencer is not idle
//   DONE       one-cycle pulse while the sequencer is in its final state
module scan_chain_ctrl #(
    parameter int                 WIDTH     = 8,
    parameter int                 CHAINS    = 1,
    parameter int                 LEN_W     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic                       CMD_CAP,
    input  logic                       CMD_UPD,
    input  logic [LEN_W-1:0]           CMD_LEN,
    input  logic [CHAINS-1:0]          SI,
    output logic [CHAINS-1:0]          SO,
    input  logic [CHAINS*WIDTH-1:0]    D,
    output logic [CHAINS*WIDTH-1:0]    Q,
    output logic                       BUSY,
    output logic                       DONE
);

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        UPDATE,
        FIN
    } state_t;

    state_t                         state_q, state_d;
    logic [LEN_W-1:0]               cnt_q, cnt_d;
    logic                           upd_q, upd_d;
    logic                           done_q, done_d;
    logic [CHAINS-1:0][WIDTH-1:0]   sr_q, sr_d;
    logic [CHAINS-1:0][WIDTH-1:0]   sh_q, sh_d;
    logic [LEN_W-1:0]               len_clamped;

    // Lengths beyond the chain width would only push the same bits further
    // out, so they are clamped to a full replacement of the chain.
    assign len_clamped = (CMD_LEN > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : CMD_LEN;

    assign CMD_READY = (state_q == IDLE);
    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;
    assign Q         = sh_q;

    always_comb begin
        for (int c = 0; c < CHAINS; c++) begin
            SO[c] = sr_q[c][0];
        end
    end

    // Next-state and datapath logic. Skipped phases cost no cycles, so every
    // exit point chooses the next non-empty phase directly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        upd_d   = upd_q;
        sr_d    = sr_q;
        sh_d    = sh_q;

        case (state_q)
            IDLE: begin
                if (CMD_VALID) begin
                    upd_d = CMD_UPD;
                    cnt_d = len_clamped;
                    if (CMD_CAP) begin
                        state_d = CAPTURE;
                    end else if (len_clamped != '0) begin
                        state_d = SHIFT;
                    end else if (CMD_UPD) begin
                        state_d = UPDATE;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            CAPTURE: begin
                sr_d = D;
                if (cnt_q != '0) begin
                    state_d = SHIFT;
                end else if (upd_q) begin
                    state_d = UPDATE;
                end else begin
                    state_d = FIN;
                end
            end
            SHIFT: begin
                for (int c = 0; c < CHAINS; c++) begin
                    sr_d[c] = {SI[c], sr_q[c][WIDTH-1:1]};
                end
                // The counter holds the number of shifts still to do,
                // including the one happening this cycle.
                if (cnt_q == LEN_W'(1)) begin
                    state_d = upd_q ? UPDATE : FIN;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            UPDATE: begin
                sh_d    = sr_q;
                state_d = FIN;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == FIN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
            sr_q    <= '0;
            for (int c = 0; c < CHAINS; c++) begin
                sh_q[c] <= RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
            done_q  <= done_d;
            sr_q    <= sr_d;
            sh_q    <= sh_d;
        end
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb_scan_chain_ctrl
//   Directed bench for scan_chain_ctrl. A single-chain instance with a
//   non-zero reset value runs a table of commands; a four-chain instance
//   runs back-to-back commands with VALID held high. A reset pulse in the
//   middle of a shift closes the run.
module tb_scan_chain_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;

    // Single-chain instance signals
    logic        valid1 = 1'b0;
    logic        ready1;
    logic        cap1 = 1'b0;
    logic        upd1 = 1'b0;
    logic [3:0]  len1 = '0;
    logic [0:0]  si1 = '0;
    logic [0:0]  so1;
    logic [7:0]  d1 = '0;
    logic [7:0]  q1;
    logic        busy1;
    logic        done1;

    // Four-chain instance signals
    logic        valid4 = 1'b0;
    logic        ready4;
    logic        cap4 = 1'b0;
    logic        upd4 = 1'b0;
    logic [3:0]  len4 = '0;
    logic [3:0]  si4 = '0;
    logic [3:0]  so4;
    logic [31:0] d4 = '0;
    logic [31:0] q4;
    logic        busy4;
    logic        done4;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    scan_chain_ctrl #(
        .WIDTH(8), .CHAINS(1), .LEN_W(4), .RESET_VAL(8'hA5)
    ) dut1 (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(valid1), .CMD_READY(ready1),
        .CMD_CAP(cap1), .CMD_UPD(upd1), .CMD_LEN(len1),
        .SI(si1), .SO(so1), .D(d1), .Q(q1),
        .BUSY(busy1), .DONE(done1)
    );

    scan_chain_ctrl #(
        .WIDTH(8), .CHAINS(4), .LEN_W(4), .RESET_VAL(8'h00)
    ) dut4 (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(valid4), .CMD_READY(ready4),
        .CMD_CAP(cap4), .CMD_UPD(upd4), .CMD_LEN(len4),
        .SI(si4), .SO(so4), .D(d4), .Q(q4),
        .BUSY(busy4), .DONE(done4)
    );

    typedef struct {
        string      name;
        logic       cap;
        logic       upd;
        logic [3:0] len;
        logic [7:0] d;
        logic [7:0] si;
        logic [7:0] exp_so;
        int         exp_lat;
        logic [7:0] exp_q;
        logic       exp_so_after;
    } vec_t;

    vec_t vecs [6];

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command to the single-chain instance from an idle cycle and
    // follow it to completion, feeding SI and checking SO on every shift.
    task automatic applyStimulus(input vec_t v);
        int cap_i;
        int clamp;
        int busy_low;
        int lat;
        cap_i    = v.cap ? 1 : 0;
        clamp    = (int'(v.len) > 8) ? 8 : int'(v.len);
        busy_low = 0;
        lat      = -1;
        checkOutput({v.name, "_ready"}, 32'(ready1), 32'd1);
        valid1 = 1'b1;
        cap1   = v.cap;
        upd1   = v.upd;
        len1   = v.len;
        d1     = v.d;
        si1    = '0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            tick();
            valid1 = 1'b0;
            cap1   = 1'b0;
            upd1   = 1'b0;
            len1   = '0;
            si1    = '0;
            if (done1) begin
                lat = cyc;
                break;
            end
            if (!busy1) busy_low++;
            if (cyc >= 1 + cap_i && cyc <= cap_i + clamp) begin
                int i;
                i = cyc - 1 - cap_i;
                si1[0] = v.si[i];
                checkOutput({v.name, "_so"}, 32'(so1), 32'(v.exp_so[i]));
            end
        end
        checkOutput({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        checkOutput({v.name, "_busy"}, 32'(busy_low), 32'd0);
        tick();
        checkOutput({v.name, "_idle"}, {29'd0, ready1, busy1, done1}, 32'b100);
        checkOutput({v.name, "_q"}, 32'(q1), 32'(v.exp_q));
        checkOutput({v.name, "_so_after"}, 32'(so1), 32'(v.exp_so_after));
    endtask

    initial begin
        logic [7:0] streams [4];
        int first_done;
        int second_done;
        int done_count;

        // name, cap, upd, len, d, si, exp_so, latency, exp_q, so_after
        vecs[0] = '{"cap_full",   1'b1, 1'b0, 4'd8,  8'h3C, 8'h00, 8'h3C, 10, 8'hA5, 1'b0};
        vecs[1] = '{"shift_upd",  1'b0, 1'b1, 4'd8,  8'hFF, 8'h8D, 8'h00, 10, 8'h8D, 1'b1};
        vecs[2] = '{"clamp15",    1'b0, 1'b0, 4'd15, 8'h00, 8'hFF, 8'h8D, 9,  8'h8D, 1'b1};
        vecs[3] = '{"partial3",   1'b0, 1'b0, 4'd3,  8'h00, 8'h00, 8'hFF, 4,  8'h8D, 1'b1};
        vecs[4] = '{"upd_only",   1'b0, 1'b1, 4'd0,  8'h00, 8'h00, 8'h00, 2,  8'h1F, 1'b1};
        vecs[5] = '{"null_cmd",   1'b0, 1'b0, 4'd0,  8'hAA, 8'h00, 8'h00, 1,  8'h1F, 1'b1};

        repeat (2) tick();
        RST = 1'b0;
        checkOutput("rst_q", 32'(q1), 32'hA5);
        checkOutput("rst_so", 32'(so1), 32'd0);
        checkOutput("rst_flags", {29'd0, ready1, busy1, done1}, 32'b100);
        checkOutput("rst_q4", q4, 32'd0);

        for (int n = 0; n < 6; n++) begin
            applyStimulus(vecs[n]);
        end

        // Back-to-back commands on four chains with VALID held high: a
        // shift+update of distinct streams, then capture+4 shifts+update.
        streams[0] = 8'h12;
        streams[1] = 8'h34;
        streams[2] = 8'hA9;
        streams[3] = 8'hF0;
        first_done  = -1;
        second_done = -1;
        valid4 = 1'b1;
        cap4   = 1'b0;
        upd4   = 1'b1;
        len4   = 4'd8;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            tick();
            if (cyc == 1) begin
                cap4 = 1'b1;
                upd4 = 1'b1;
                len4 = 4'd4;
                d4   = 32'h7E815AC3;
            end
            for (int c = 0; c < 4; c++) begin
                si4[c] = (cyc <= 8) ? streams[c][cyc-1] : 1'b0;
            end
            if (done4) begin
                if (first_done < 0) first_done = cyc;
                else if (second_done < 0) second_done = cyc;
            end
            if (cyc == 11) begin
                checkOutput("b2b_ready", 32'(ready4), 32'd1);
                checkOutput("b2b_q_first", q4, 32'hF0A93412);
            end
            if (cyc == 12) begin
                checkOutput("b2b_accepted", {30'd0, ready4, busy4}, 32'b01);
                valid4 = 1'b0;
            end
            if (cyc == 19) begin
                checkOutput("b2b_q_second", q4, 32'h0708050C);
                checkOutput("b2b_idle", 32'(ready4), 32'd1);
            end
        end
        checkOutput("b2b_done1", 32'(first_done), 32'd10);
        checkOutput("b2b_done2", 32'(second_done), 32'd18);

        // Reset in the middle of a shift aborts the command silently.
        valid1 = 1'b1;
        cap1   = 1'b1;
        upd1   = 1'b1;
        len1   = 4'd8;
        d1     = 8'hFF;
        si1    = 1'b1;
        tick();
        valid1 = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("abort_mid_so", 32'(so1), 32'd1);
        checkOutput("abort_mid_busy", 32'(busy1), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("abort_q", 32'(q1), 32'hA5);
        checkOutput("abort_so", 32'(so1), 32'd0);
        checkOutput("abort_flags", {29'd0, ready1, busy1, done1}, 32'b100);
        done_count = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tick();
            if (done1) done_count++;
        end
        checkOutput("abort_no_done", 32'(done_count), 32'd0);
        checkOutput("abort_q_hold", 32'(q1), 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
